// File: rtl/core_mem_pkg.sv
// Shared constants, FSM state type and load-target encodings for the
// core memory responder.
package core_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_DATA = 1'b1;

endpackage

// File: rtl/mem_sync_rf.sv
// Single-write, single-registered-read word array. Reads are read-first:
// a same-cycle write to the read address returns the old word.
module mem_sync_rf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = clr ? '0 : mem_q[raddr];
  end

  // Contents are deliberately never reset so a partial reload keeps old words.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the pipelined core: host load phase, then core
// instruction/data service. Optional macro RESPONDER_WR_COUNT_EN adds wr_count.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int DATA_W = core_mem_pkg::DATA_W,
  parameter int ADDR_W = core_mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address_to_inst_mem,
  output logic [DATA_W-1:0] data_from_inst_memory,
  input  logic [ADDR_W-1:0] address_to_main_mem,
  input  logic [DATA_W-1:0] data_to_main_mem,
  input  logic              data_to_main_mem_write_en,
  output logic [DATA_W-1:0] data_from_main_memory,
  output logic              core_rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [DATA_W-1:0] load_data,
`ifdef RESPONDER_WR_COUNT_EN
  input  logic              load_done,
  output logic [15:0]       wr_count
`else
  input  logic              load_done
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_i_q, cnt_i_d;
  logic [ADDR_W-1:0] cnt_d_q, cnt_d_d;

  logic              load_fire;
  logic              core_wr;
  logic              rd_clr;
  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;

  // Handshake: a load word transfers on a cycle where load_valid && load_ready;
  // load_ready is high only in LOAD with rst low, and never stalls otherwise.
  assign load_ready = (state_q == LOAD) && !rst;
  assign load_fire  = load_valid && load_ready;
  assign core_wr    = (state_q == RUN) && !rst && data_to_main_mem_write_en;
  assign core_rst   = (state_q == LOAD);
  assign rd_clr     = rst || (state_q != RUN);

  always_comb begin
    state_d = state_q;
    cnt_i_d = cnt_i_q;
    cnt_d_d = cnt_d_q;
    case (state_q)
      LOAD: begin
        if (load_fire && (load_sel == SEL_INST)) cnt_i_d = cnt_i_q + 1'b1;
        if (load_fire && (load_sel == SEL_DATA)) cnt_d_d = cnt_d_q + 1'b1;
        if (load_done) state_d = RUN;
      end
      RUN: begin
        state_d = RUN;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_i_q <= '0;
      cnt_d_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
    end
  end

  always_comb begin
    imem_we    = load_fire && (load_sel == SEL_INST);
    dmem_we    = core_wr || (load_fire && (load_sel == SEL_DATA));
    dmem_waddr = core_wr ? address_to_main_mem : cnt_d_q;
    dmem_wdata = core_wr ? data_to_main_mem : load_data;
  end

  mem_sync_rf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk     (clk),
    .clr     (rd_clr),
    .we      (imem_we),
    .waddr   (cnt_i_q),
    .wdata   (load_data),
    .raddr   (address_to_inst_mem),
    .rd_data (data_from_inst_memory)
  );

  mem_sync_rf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .clr     (rd_clr),
    .we      (dmem_we),
    .waddr   (dmem_waddr),
    .wdata   (dmem_wdata),
    .raddr   (address_to_main_mem),
    .rd_data (data_from_main_memory)
  );

`ifdef RESPONDER_WR_COUNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (core_wr && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_count_q <= '0;
    else     wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench for core_mem_responder: directed tables, multi-cycle
// corner sequences and randomized traffic against a word-array reference model.
module tb_core_mem_responder;

  logic        clk;
  logic        rst;
  logic [4:0]  address_to_inst_mem;
  logic [15:0] data_from_inst_memory;
  logic [4:0]  address_to_main_mem;
  logic [15:0] data_to_main_mem;
  logic        data_to_main_mem_write_en;
  logic [15:0] data_from_main_memory;
  logic        core_rst;
  logic        load_valid;
  logic        load_ready;
  logic        load_sel;
  logic [15:0] load_data;
  logic        load_done;
`ifdef RESPONDER_WR_COUNT_EN
  logic [15:0] wr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  core_mem_responder dut (
    .clk                       (clk),
    .rst                       (rst),
    .address_to_inst_mem       (address_to_inst_mem),
    .data_from_inst_memory     (data_from_inst_memory),
    .address_to_main_mem       (address_to_main_mem),
    .data_to_main_mem          (data_to_main_mem),
    .data_to_main_mem_write_en (data_to_main_mem_write_en),
    .data_from_main_memory     (data_from_main_memory),
    .core_rst                  (core_rst),
    .load_valid                (load_valid),
    .load_ready                (load_ready),
    .load_sel                  (load_sel),
    .load_data                 (load_data),
`ifdef RESPONDER_WR_COUNT_EN
    .load_done                 (load_done),
    .wr_count                  (wr_count)
`else
    .load_done                 (load_done)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two plain word arrays, per-memory fill pointers, a run flag.
  logic [15:0] imem_m [32];
  logic [15:0] dmem_m [32];
  int          m_li = 0;
  int          m_ld = 0;
  bit          m_run = 1'b0;
  logic [15:0] exp_i = '0;
  logic [15:0] exp_d = '0;
  int          m_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs being applied, then compare.
  task automatic tick();
    logic [15:0] ni, nd;
    bit          nrun;
    ni = '0;
    nd = '0;
    nrun = m_run;
    if (rst) begin
      nrun = 1'b0;
      m_li = 0;
      m_ld = 0;
      m_wr = 0;
    end else if (!m_run) begin
      if (load_valid) begin
        if (load_sel) begin dmem_m[m_ld] = load_data; m_ld = (m_ld + 1) % 32; end
        else          begin imem_m[m_li] = load_data; m_li = (m_li + 1) % 32; end
      end
      if (load_done) nrun = 1'b1;
    end else begin
      ni = imem_m[address_to_inst_mem];
      nd = dmem_m[address_to_main_mem];
      if (data_to_main_mem_write_en) begin
        dmem_m[address_to_main_mem] = data_to_main_mem;
        if (m_wr < 65535) m_wr++;
      end
    end
    @(posedge clk);
    #2;
    m_run = nrun;
    exp_i = ni;
    exp_d = nd;
    chk("model_core_rst", {31'd0, core_rst}, {31'd0, !m_run});
    chk("model_load_ready", {31'd0, load_ready}, {31'd0, (!m_run && !rst)});
    if (!$isunknown(exp_i)) chk("model_inst_rd", {16'd0, data_from_inst_memory}, {16'd0, exp_i});
    if (!$isunknown(exp_d)) chk("model_data_rd", {16'd0, data_from_main_memory}, {16'd0, exp_d});
`ifdef RESPONDER_WR_COUNT_EN
    chk("model_wr_count", {16'd0, wr_count}, m_wr);
`endif
  endtask

  task automatic load_word(input logic sel, input logic [15:0] data);
    load_valid = 1'b1;
    load_sel   = sel;
    load_data  = data;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [15:0] data;
  } load_vec_t;

  typedef struct {
    logic [4:0]  ai;
    logic [4:0]  ad;
    logic        we;
    logic [15:0] wd;
    logic [15:0] ei;
    logic [15:0] ed;
    bit          chk_d;
  } run_vec_t;

  load_vec_t load_tbl [6];
  run_vec_t  run_tbl [5];

  initial begin
    load_tbl[0] = '{1'b0, 16'h1000};
    load_tbl[1] = '{1'b0, 16'h1001};
    load_tbl[2] = '{1'b0, 16'h1002};
    load_tbl[3] = '{1'b0, 16'h1003};
    load_tbl[4] = '{1'b1, 16'hA000};
    load_tbl[5] = '{1'b1, 16'hA001};

    run_tbl[0] = '{5'd2, 5'd0, 1'b0, 16'h0000, 16'h1002, 16'hA000, 1'b1};
    run_tbl[1] = '{5'd1, 5'd7, 1'b1, 16'hBEEF, 16'h1001, 16'h0000, 1'b0};
    run_tbl[2] = '{5'd2, 5'd7, 1'b0, 16'h0000, 16'h1002, 16'hBEEF, 1'b1};
    run_tbl[3] = '{5'd0, 5'd1, 1'b1, 16'h1234, 16'h1000, 16'hA001, 1'b1};
    run_tbl[4] = '{5'd0, 5'd1, 1'b0, 16'h0000, 16'h1000, 16'h1234, 1'b1};

    rst = 1'b1;
    address_to_inst_mem = '0;
    address_to_main_mem = '0;
    data_to_main_mem = '0;
    data_to_main_mem_write_en = 1'b0;
    load_valid = 1'b0;
    load_sel = 1'b0;
    load_data = '0;
    load_done = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_inst_out", {16'd0, data_from_inst_memory}, 32'd0);
    chk("rst_data_out", {16'd0, data_from_main_memory}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("load_ready_after_rst", {31'd0, load_ready}, 32'd1);

    // Directed load, then core_rst falls one cycle after load_done
    for (int i = 0; i < 6; i++) load_word(load_tbl[i].sel, load_tbl[i].data);
    load_done = 1'b1;
    #1;
    chk("core_rst_before_done_edge", {31'd0, core_rst}, 32'd1);
    tick();
    load_done = 1'b0;
    chk("core_rst_fall", {31'd0, core_rst}, 32'd0);

    // Directed RUN reads/writes including read-during-write
    for (int i = 0; i < 5; i++) begin
      address_to_inst_mem = run_tbl[i].ai;
      address_to_main_mem = run_tbl[i].ad;
      data_to_main_mem_write_en = run_tbl[i].we;
      data_to_main_mem = run_tbl[i].wd;
      tick();
      data_to_main_mem_write_en = 1'b0;
      chk($sformatf("run_tbl_inst[%0d]", i), {16'd0, data_from_inst_memory}, {16'd0, run_tbl[i].ei});
      if (run_tbl[i].chk_d)
        chk($sformatf("run_tbl_data[%0d]", i), {16'd0, data_from_main_memory}, {16'd0, run_tbl[i].ed});
    end

    // Reset mid-RUN keeps memory contents
    rst = 1'b1;
    tick();
    chk("midrst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("midrst_inst_out", {16'd0, data_from_inst_memory}, 32'd0);
    chk("midrst_data_out", {16'd0, data_from_main_memory}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_load_ready", {31'd0, load_ready}, 32'd1);
    finish_load();
    address_to_main_mem = 5'd7;
    tick();
    tick();
    chk("retained_dmem7", {16'd0, data_from_main_memory}, 32'h0000BEEF);

`ifdef RESPONDER_WR_COUNT_EN
    for (int i = 0; i < 5; i++) begin
      address_to_main_mem = 5'(20 + i);
      data_to_main_mem = 16'(16'h5000 + i);
      data_to_main_mem_write_en = 1'b1;
      tick();
    end
    data_to_main_mem_write_en = 1'b0;
    chk("wr_count_5", {16'd0, wr_count}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wr_count_rst", {16'd0, wr_count}, 32'd0);
    load_word(1'b1, 16'h7777);
    load_word(1'b0, 16'h8888);
    chk("wr_count_load", {16'd0, wr_count}, 32'd0);
`endif

    // Counter wrap: 33 instruction words
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) load_word(1'b0, 16'(16'h2000 + k));
    finish_load();
    address_to_inst_mem = 5'd0;
    tick();
    tick();
    chk("wrap_imem0", {16'd0, data_from_inst_memory}, 32'h00002021);
    address_to_inst_mem = 5'd1;
    tick();
    chk("wrap_imem1", {16'd0, data_from_inst_memory}, 32'h00002002);
    address_to_inst_mem = 5'd0;
    load_valid = 1'b1;
    load_sel = 1'b0;
    load_data = 16'hDEAD;
    #1;
    chk("run_load_ready", {31'd0, load_ready}, 32'd0);
    tick();
    load_valid = 1'b0;
    tick();
    chk("run_load_ignored", {16'd0, data_from_inst_memory}, 32'h00002021);

    // Randomized traffic against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int ni_left, nd_left;
      ni_left = 32;
      nd_left = 32;
      while (ni_left + nd_left > 0) begin
        if ($urandom_range(0, 3) == 0) begin
          tick();
        end else if (nd_left == 0 || (ni_left > 0 && $urandom_range(0, 1) == 0)) begin
          load_word(1'b0, 16'($urandom));
          ni_left--;
        end else begin
          load_word(1'b1, 16'($urandom));
          nd_left--;
        end
      end
    end
    load_valid = 1'($urandom_range(0, 1));
    load_sel = 1'($urandom_range(0, 1));
    load_data = 16'($urandom);
    finish_load();
    load_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      address_to_inst_mem = 5'($urandom_range(0, 31));
      address_to_main_mem = 5'($urandom_range(0, 31));
      data_to_main_mem = 16'($urandom);
      data_to_main_mem_write_en = 1'($urandom_range(0, 1));
      load_valid = 1'($urandom_range(0, 1));
      load_sel = 1'($urandom_range(0, 1));
      load_data = 16'($urandom);
      load_done = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) begin
        data_to_main_mem_write_en = 1'b0;
        load_valid = 1'b0;
        load_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int w = 0; w < 4; w++) load_word(1'($urandom_range(0, 1)), 16'($urandom));
        finish_load();
      end else begin
        tick();
      end
    end
    data_to_main_mem_write_en = 1'b0;
    load_valid = 1'b0;
    load_done = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
